// File: rtl/ac_mode_sequencer_pkg.sv
// Shared constants, state encoding and actuator decode for the AC sequencer.
// Mode bit positions match the comparator stage's ac_working_mode layout.
package ac_mode_sequencer_pkg;

    localparam int AC_HEAT_MODE_BIT   = 0;
    localparam int AC_COOL_MODE_BIT   = 1;
    localparam int AC_SEQ_STATE_WIDTH = 3;

    localparam int AC_PRE_FAN_TICKS_DEF  = 2;
    localparam int AC_MIN_ON_TICKS_DEF   = 10;
    localparam int AC_POST_FAN_TICKS_DEF = 3;
    localparam int AC_LOCKOUT_TICKS_DEF  = 5;
    localparam int AC_CNT_W_DEF          = 8;

    typedef enum logic [AC_SEQ_STATE_WIDTH-1:0] {
        AC_SEQ_IDLE     = 3'd0,
        AC_SEQ_PRE_FAN  = 3'd1,
        AC_SEQ_HEAT     = 3'd2,
        AC_SEQ_COOL     = 3'd3,
        AC_SEQ_POST_FAN = 3'd4
    } ac_seq_state_e;

    typedef struct packed {
        logic heater;
        logic cooler;
        logic fan;
        logic busy;
    } ac_act_t;

    function automatic ac_act_t ac_decode(input ac_seq_state_e s);
        ac_act_t a;
        a.heater = (s == AC_SEQ_HEAT);
        a.cooler = (s == AC_SEQ_COOL);
        a.fan    = (s == AC_SEQ_PRE_FAN) || (s == AC_SEQ_HEAT) ||
                   (s == AC_SEQ_COOL) || (s == AC_SEQ_POST_FAN);
        a.busy   = (s != AC_SEQ_IDLE);
        return a;
    endfunction

endpackage

// File: rtl/ac_mode_sequencer_if.sv
// Comparator-side requests in, actuator drives and status out.
// master = request/timebase source, slave = the sequencer.
interface ac_mode_sequencer_if;
    import ac_mode_sequencer_pkg::*;

    logic                          tick_i;
    logic [1:0]                    ac_working_mode_i;
    logic                          heat_req_i;
    logic                          cool_req_i;
    logic                          heater_en_o;
    logic                          cooler_en_o;
    logic                          fan_en_o;
    logic [AC_SEQ_STATE_WIDTH-1:0] state_o;
    logic                          busy_o;

    modport master (
        output tick_i, ac_working_mode_i, heat_req_i, cool_req_i,
        input  heater_en_o, cooler_en_o, fan_en_o, state_o, busy_o
    );

    modport slave (
        input  tick_i, ac_working_mode_i, heat_req_i, cool_req_i,
        output heater_en_o, cooler_en_o, fan_en_o, state_o, busy_o
    );

endinterface

// File: rtl/ac_tick_counter.sv
// Phase counter: clears on state entry, saturates at limit_i.
// done_o flags the tick that completes limit_i ticks.
module ac_tick_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic             done_o,
    output logic             sat_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (tick_i && (cnt_q < limit_i)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = tick_i && (limit_i != '0) && (cnt_q == limit_i - 1'b1);
    assign sat_o  = (cnt_q >= limit_i);

endmodule

// File: rtl/ac_mode_sequencer.sv
// AC actuator sequencer: fan pre/post-run, element min-on time and
// compressor restart lockout, with heater and cooler mutually exclusive.
module ac_mode_sequencer
    import ac_mode_sequencer_pkg::*;
#(
    parameter int PRE_FAN_TICKS  = AC_PRE_FAN_TICKS_DEF,
    parameter int MIN_ON_TICKS   = AC_MIN_ON_TICKS_DEF,
    parameter int POST_FAN_TICKS = AC_POST_FAN_TICKS_DEF,
    parameter int LOCKOUT_TICKS  = AC_LOCKOUT_TICKS_DEF,
    parameter int CNT_W          = AC_CNT_W_DEF
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    ac_mode_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] PRE_LIM  = CNT_W'(PRE_FAN_TICKS);
    localparam logic [CNT_W-1:0] MIN_LIM  = CNT_W'(MIN_ON_TICKS);
    localparam logic [CNT_W-1:0] POST_LIM = CNT_W'(POST_FAN_TICKS);
    localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCKOUT_TICKS);

    ac_seq_state_e    state_q, state_d;
    logic             tgt_cool_q, tgt_cool_d;
    logic [CNT_W-1:0] lock_q, lock_d;
    ac_act_t          act_q, act_d;

    logic             heat_q, cool_q;
    logic             mode_heat, mode_cool;
    logic [CNT_W-1:0] ph_limit;
    logic             ph_clr, ph_done, ph_sat;

    assign mode_heat = bus.ac_working_mode_i[AC_HEAT_MODE_BIT];
    assign mode_cool = bus.ac_working_mode_i[AC_COOL_MODE_BIT];
    assign heat_q    = bus.heat_req_i & mode_heat;
    assign cool_q    = bus.cool_req_i & mode_cool;

    always_comb begin
        ph_limit = '0;
        unique case (state_q)
            AC_SEQ_PRE_FAN:  ph_limit = PRE_LIM;
            AC_SEQ_HEAT:     ph_limit = MIN_LIM;
            AC_SEQ_COOL:     ph_limit = MIN_LIM;
            AC_SEQ_POST_FAN: ph_limit = POST_LIM;
            default:         ph_limit = '0;
        endcase
    end

    ac_tick_counter #(
        .CNT_W (CNT_W)
    ) u_phase (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (ph_clr),
        .tick_i  (bus.tick_i),
        .limit_i (ph_limit),
        .done_o  (ph_done),
        .sat_o   (ph_sat)
    );

    always_comb begin
        state_d    = state_q;
        tgt_cool_d = tgt_cool_q;
        unique case (state_q)
            AC_SEQ_IDLE: begin
                if (heat_q) begin
                    state_d    = AC_SEQ_PRE_FAN;
                    tgt_cool_d = 1'b0;
                end else if (cool_q && (lock_q == '0)) begin
                    state_d    = AC_SEQ_PRE_FAN;
                    tgt_cool_d = 1'b1;
                end
            end
            AC_SEQ_PRE_FAN: begin
                // Losing the target request aborts before the element ever starts
                if (tgt_cool_q ? !cool_q : !heat_q) begin
                    state_d = AC_SEQ_IDLE;
                end else if (ph_done) begin
                    state_d = tgt_cool_q ? AC_SEQ_COOL : AC_SEQ_HEAT;
                end
            end
            AC_SEQ_HEAT: begin
                if (!mode_heat || (!heat_q && ph_sat)) begin
                    state_d = AC_SEQ_POST_FAN;
                end
            end
            AC_SEQ_COOL: begin
                if (!mode_cool || (!cool_q && ph_sat)) begin
                    state_d = AC_SEQ_POST_FAN;
                end
            end
            AC_SEQ_POST_FAN: begin
                if (ph_done) begin
                    state_d = AC_SEQ_IDLE;
                end
            end
            default: begin
                state_d = AC_SEQ_IDLE;
            end
        endcase
    end

    assign ph_clr = (state_d != state_q);

    always_comb begin
        lock_d = lock_q;
        if ((state_q == AC_SEQ_COOL) && (state_d != AC_SEQ_COOL)) begin
            lock_d = LOCK_LIM;
        end else if (bus.tick_i && (lock_q != '0)) begin
            lock_d = lock_q - 1'b1;
        end
    end

    assign act_d = ac_decode(state_d);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= AC_SEQ_IDLE;
            tgt_cool_q <= 1'b0;
            lock_q     <= '0;
            act_q      <= '0;
        end else begin
            state_q    <= state_d;
            tgt_cool_q <= tgt_cool_d;
            lock_q     <= lock_d;
            act_q      <= act_d;
        end
    end

    assign bus.heater_en_o = act_q.heater;
    assign bus.cooler_en_o = act_q.cooler;
    assign bus.fan_en_o    = act_q.fan;
    assign bus.busy_o      = act_q.busy;
    assign bus.state_o     = state_q;

endmodule
